follow_ctrl: RTL and testbench
==============================

Name: follow_ctrl

Overview:
- Motion controller that consumes the per-frame centroid and proximity results from the colour-centroid stage.
- Sequences the robot through search, track and hold behaviour, and turns each result into left/right wheel duty cycles and directions.
- Sits between the vision pipeline (centroid/proximity, one-pulse `new_centroid`) and the motor H-bridge pins.
- Owns lost-target timeout, steering-to-duty mapping and glitch-free PWM generation.

Parameters:
- c_nb_centroid, 8: centroid code width; one-hot-ish code, bit0 = leftmost, bit7 = rightmost, 8'h18 = centred.
- c_nb_prox, 3: proximity width; 0 = far, 7 = close.
- c_pwm_period, 2000: PWM period in clk cycles.
- c_nb_pwm, $clog2(c_pwm_period+1): duty/counter width; duty == c_pwm_period means 100 %.
- c_duty_max, 1600: full tracking duty. Must be ≤ c_pwm_period.
- c_search_duty, 800: spin duty in SEARCH.
- c_slow_prox, 3: proximity at or above which base duty halves.
- c_stop_prox, 4: proximity at or above which a centred target causes HOLD.
- c_lost_frames, 8: consecutive no-target frames before returning to SEARCH.

Ports:
- clk  in  1  fpga clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- enable_i  in  1  run enable; 0 forces IDLE.
- new_centroid_i  in  1  one-cycle pulse; centroid_i and proximity_i are valid in that cycle.
- centroid_i  in  c_nb_centroid  centroid code.
- proximity_i  in  c_nb_prox  proximity.
- motor_l_pwm_o  out  1  left wheel PWM.
- motor_r_pwm_o  out  1  right wheel PWM.
- motor_l_dir_o  out  1  left direction; 1 = forward.
- motor_r_dir_o  out  1  right direction; 1 = forward.
- state_o  out  2  current state: IDLE=0, SEARCH=1, TRACK=2, HOLD=3.
- new_cmd_o  out  1  one-cycle pulse when a new duty pair has been latched.

Behaviour:
- **Reset (synchronous, rst=1 at a clk edge).** All outputs 0; state IDLE; PWM counter 0; active and shadow duties 0; lost counter 0. Reset mid-period takes effect on that same edge, with no wait for the period boundary.
- **Valid codes.** 8'h18, or exactly one bit set. Any other value, including 8'h00, is "no target".
- **Evaluation.** Occurs only in cycles with new_centroid_i=1 and enable_i=1. The next state and shadow duties are registered at that edge. new_cmd_o pulses in the following cycle.
- **enable_i low.** Next edge: state IDLE, active duties forced to 0 immediately, lost counter cleared. enable_i=0 wins over a simultaneous new_centroid_i.
- **IDLE.**
  - Duties 0, dirs 1.
  - enable_i=1 → SEARCH on the next edge, with no frame needed.
  - On entry to SEARCH: shadow duties = c_search_duty, dir_l=0, dir_r=1 (spin left).
- **SEARCH.** A valid target → TRACK. Duties are computed from that same frame. Lost counter = 0.
- **TRACK.**
  - No target: lost counter +1 (saturating) and duties kept. When the counter reaches c_lost_frames → SEARCH.
  - Valid target: lost counter = 0.
    - Code 8'h18 with proximity ≥ c_stop_prox → HOLD, duties 0.
    - Otherwise stay in TRACK with the duty mapping below. Both dirs = 1.
- **HOLD.**
  - Duties 0.
  - Valid target with proximity < c_stop_prox → TRACK, duty mapping applied.
  - A valid off-centre code → TRACK, duty mapping applied.
  - No target: lost counting as in TRACK.
- **Duty mapping.**
  - base = c_duty_max if proximity < c_slow_prox, else c_duty_max>>1.
  - Code 8'h18: L = R = base.
  - Left codes 8'h08 / 8'h04 / 8'h02 / 8'h01 → L = base-(base>>2) / base>>1 / base>>2 / 0, with R = base.
  - Right codes 8'h10 / 8'h20 / 8'h40 / 8'h80 mirror this: R reduced by the same amounts, L = base.
  - Arithmetic uses shifts only and is c_nb_pwm wide; no overflow is possible.
- **PWM.**
  - Free-running counter 0..c_pwm_period-1, wrapping to 0.
  - Shadow duties and dirs copy into active registers only on the cycle the counter is 0. The exception is the forced-zero cases (rst, enable low).
  - pwm_o = (counter < active_duty), registered, so it lags the counter by 1 cycle.
  - Duty 0 → constantly low. Duty = c_pwm_period → constantly high.
- **Latency.** A new_centroid_i at edge N makes the shadow update visible at N+1. It reaches the pins at the first counter wrap after N+1.

Decomposition:
- Package follow_pkg:
  - state encoding constants.
  - centroid code constants (CENTRE=8'h18, L1..L4, R1..R4).
  - direction constants.
- Sub-module pwm_gen, parameterised by c_pwm_period and c_nb_pwm. Contents:
  - shared counter.
  - two shadow/active duty channels.
  - direction registers.
  - force-zero input.
- The FSM, lost counter and duty mapping stay in follow_ctrl.

Test Plan:
Common parameters: c_pwm_period=100, c_duty_max=80, c_search_duty=40, c_lost_frames=4, c_slow_prox=3, c_stop_prox=4.
1. rst then enable_i=1 → state_o=1; after the next wrap both PWMs are high for 40 of every 100 cycles; dir_l=0, dir_r=1.
2. In SEARCH, frame 8'h18 with prox 1 → state_o=2; new_cmd_o pulses 1 cycle later; after the wrap L=R=80 high cycles per period; dirs 1/1.
3. In TRACK, frame 8'h02 with prox 3 → L=10, R=40. Then frame 8'h40 with prox 0 → L=80, R=20.
4. Lost handling:
   - Three frames of 8'h00 then 8'h18 → stays in TRACK.
   - Then four frames of 8'h00 (or 8'h05) → state_o=1 on the 4th frame; search duties at the next wrap.
5. Hold:
   - Frame 8'h18 with prox 5 → state_o=3, both PWMs low.
   - Then 8'h18 with prox 2 → TRACK, L=R=80.
   - Then 8'h01 with prox 6 in TRACK → L=0, R=40.
6. Mid-period forcing:
   - Mid-period in TRACK (counter=30, duty 80): drop enable_i → PWMs low from the next cycle, state_o=0.
   - Same setup with rst=1 for one cycle instead → all outputs 0 on that edge.
   - enable_i=0 together with new_centroid_i → IDLE, no new_cmd_o.

Source files
------------

// File: rtl/follow_pkg.sv
// Shared encodings for the follow controller: FSM states, centroid codes and
// wheel direction values, plus the centroid validity test.
package follow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Bit 0 is the leftmost image column, bit 7 the rightmost.
  localparam logic [7:0] CODE_CENTRE = 8'h18;
  localparam logic [7:0] CODE_L1     = 8'h08;
  localparam logic [7:0] CODE_L2     = 8'h04;
  localparam logic [7:0] CODE_L3     = 8'h02;
  localparam logic [7:0] CODE_L4     = 8'h01;
  localparam logic [7:0] CODE_R1     = 8'h10;
  localparam logic [7:0] CODE_R2     = 8'h20;
  localparam logic [7:0] CODE_R3     = 8'h40;
  localparam logic [7:0] CODE_R4     = 8'h80;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // A target is either the two-bit centre code or a single set bit.
  function automatic logic code_valid(input logic [7:0] code);
    return (code == CODE_CENTRE) ||
           ((code != 8'h00) && ((code & (code - 8'd1)) == 8'h00));
  endfunction

endpackage

// File: rtl/follow_ctrl_pwm_gen.sv
// Two-channel PWM with a shared free-running counter. Shadow duty/direction
// values move to the active set only at counter zero, so pins never glitch.
module pwm_gen
  import follow_pkg::*;
#(
  parameter int c_pwm_period = 2000,
  parameter int c_nb_pwm     = $clog2(c_pwm_period + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                force_zero_i,
  input  logic                load_i,
  input  logic [c_nb_pwm-1:0] duty_l_i,
  input  logic [c_nb_pwm-1:0] duty_r_i,
  input  logic                dir_l_i,
  input  logic                dir_r_i,
  output logic                pwm_l_o,
  output logic                pwm_r_o,
  output logic                dir_l_o,
  output logic                dir_r_o
);

  localparam logic [c_nb_pwm-1:0] c_last = c_nb_pwm'(c_pwm_period - 1);

  logic [c_nb_pwm-1:0] cnt_q, cnt_d;
  logic                wrap;

  always_comb begin
    cnt_d = (cnt_q == c_last) ? '0 : cnt_q + 1'b1;
    wrap  = (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  logic [1:0][c_nb_pwm-1:0] duty_in;
  logic [1:0]               dir_in;
  logic [1:0]               pwm_vec;
  logic [1:0]               dir_vec;

  assign duty_in = {duty_r_i, duty_l_i};
  assign dir_in  = {dir_r_i, dir_l_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [c_nb_pwm-1:0] shd_q, shd_d, act_q, act_d;
      logic                sdir_q, sdir_d, adir_q, adir_d;
      logic                pwm_q, pwm_d;

      always_comb begin
        shd_d  = shd_q;
        sdir_d = sdir_q;
        act_d  = act_q;
        adir_d = adir_q;
        if (load_i) begin
          shd_d  = duty_in[gi];
          sdir_d = dir_in[gi];
        end
        if (wrap) begin
          act_d  = shd_q;
          adir_d = sdir_q;
        end
        // Forcing bypasses the period boundary and parks the shadow at idle.
        if (force_zero_i) begin
          shd_d  = '0;
          sdir_d = DIR_FWD;
          act_d  = '0;
        end
        pwm_d = !force_zero_i && (cnt_q < act_d);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          shd_q  <= '0;
          sdir_q <= 1'b0;
          act_q  <= '0;
          adir_q <= 1'b0;
          pwm_q  <= 1'b0;
        end else begin
          shd_q  <= shd_d;
          sdir_q <= sdir_d;
          act_q  <= act_d;
          adir_q <= adir_d;
          pwm_q  <= pwm_d;
        end
      end

      assign pwm_vec[gi] = pwm_q;
      assign dir_vec[gi] = adir_q;
    end
  endgenerate

  assign pwm_l_o = pwm_vec[0];
  assign pwm_r_o = pwm_vec[1];
  assign dir_l_o = dir_vec[0];
  assign dir_r_o = dir_vec[1];

endmodule

// File: rtl/follow_ctrl.sv
// Search/track/hold sequencer: turns per-frame centroid and proximity results
// into wheel duty/direction commands for the PWM generator.
module follow_ctrl
  import follow_pkg::*;
#(
  parameter int c_nb_centroid = 8,
  parameter int c_nb_prox     = 3,
  parameter int c_pwm_period  = 2000,
  parameter int c_nb_pwm      = $clog2(c_pwm_period + 1),
  parameter int c_duty_max    = 1600,
  parameter int c_search_duty = 800,
  parameter int c_slow_prox   = 3,
  parameter int c_stop_prox   = 4,
  parameter int c_lost_frames = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     new_centroid_i,
  input  logic [c_nb_centroid-1:0] centroid_i,
  input  logic [c_nb_prox-1:0]     proximity_i,
  output logic                     motor_l_pwm_o,
  output logic                     motor_r_pwm_o,
  output logic                     motor_l_dir_o,
  output logic                     motor_r_dir_o,
  output logic [1:0]               state_o,
  output logic                     new_cmd_o
);

  localparam int c_nb_lost = $clog2(c_lost_frames + 1);
  localparam logic [c_nb_pwm-1:0]  c_full   = c_nb_pwm'(c_duty_max);
  localparam logic [c_nb_pwm-1:0]  c_search = c_nb_pwm'(c_search_duty);
  localparam logic [c_nb_lost-1:0] c_lost   = c_nb_lost'(c_lost_frames);

  state_e               state_q, state_d;
  logic [c_nb_lost-1:0] lost_q, lost_d, lost_inc;
  logic                 new_cmd_q, new_cmd_d;

  logic                valid, centre, close;
  logic [c_nb_pwm-1:0] base, map_l, map_r;
  logic                load;
  logic [c_nb_pwm-1:0] shd_l, shd_r;
  logic                shd_dir_l, shd_dir_r;

  always_comb begin
    valid  = code_valid(centroid_i);
    centre = (centroid_i == CODE_CENTRE);
    close  = (proximity_i >= c_nb_prox'(c_stop_prox));
    base   = (proximity_i < c_nb_prox'(c_slow_prox)) ? c_full : (c_full >> 1);
    map_l  = base;
    map_r  = base;
    // Steer by slowing the wheel on the side the target lies.
    case (centroid_i)
      CODE_L1: map_l = base - (base >> 2);
      CODE_L2: map_l = base >> 1;
      CODE_L3: map_l = base >> 2;
      CODE_L4: map_l = '0;
      CODE_R1: map_r = base - (base >> 2);
      CODE_R2: map_r = base >> 1;
      CODE_R3: map_r = base >> 2;
      CODE_R4: map_r = '0;
      default: ;
    endcase
  end

  always_comb begin
    lost_inc  = (lost_q >= c_lost) ? lost_q : lost_q + 1'b1;
    state_d   = state_q;
    lost_d    = lost_q;
    load      = 1'b0;
    shd_l     = map_l;
    shd_r     = map_r;
    shd_dir_l = DIR_FWD;
    shd_dir_r = DIR_FWD;

    if (!enable_i) begin
      state_d = ST_IDLE;
      lost_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_SEARCH;
          lost_d    = '0;
          load      = 1'b1;
          shd_l     = c_search;
          shd_r     = c_search;
          shd_dir_l = DIR_REV;
        end
        ST_SEARCH: begin
          if (new_centroid_i && valid) begin
            state_d = ST_TRACK;
            lost_d  = '0;
            load    = 1'b1;
          end
        end
        default: begin
          if (new_centroid_i) begin
            if (!valid) begin
              if (lost_inc == c_lost) begin
                state_d   = ST_SEARCH;
                lost_d    = '0;
                load      = 1'b1;
                shd_l     = c_search;
                shd_r     = c_search;
                shd_dir_l = DIR_REV;
              end else begin
                lost_d = lost_inc;
              end
            end else begin
              lost_d = '0;
              load   = 1'b1;
              if (centre && close) begin
                state_d = ST_HOLD;
                shd_l   = '0;
                shd_r   = '0;
              end else begin
                state_d = ST_TRACK;
              end
            end
          end
        end
      endcase
    end
    new_cmd_d = load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lost_q    <= '0;
      new_cmd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lost_q    <= lost_d;
      new_cmd_q <= new_cmd_d;
    end
  end

  pwm_gen #(
    .c_pwm_period (c_pwm_period),
    .c_nb_pwm     (c_nb_pwm)
  ) u_pwm (
    .clk          (clk),
    .rst          (rst),
    .force_zero_i (!enable_i),
    .load_i       (load),
    .duty_l_i     (shd_l),
    .duty_r_i     (shd_r),
    .dir_l_i      (shd_dir_l),
    .dir_r_i      (shd_dir_r),
    .pwm_l_o      (motor_l_pwm_o),
    .pwm_r_o      (motor_r_pwm_o),
    .dir_l_o      (motor_l_dir_o),
    .dir_r_o      (motor_r_dir_o)
  );

  assign state_o   = state_q;
  assign new_cmd_o = new_cmd_q;

endmodule

// File: tb/tb_follow_ctrl.sv
// Directed bench for follow_ctrl with a 100-cycle PWM period; duty is measured
// as high cycles over one full period window.
module tb_follow_ctrl;

  localparam int P = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_i = 1'b0;
  logic       new_centroid_i = 1'b0;
  logic [7:0] centroid_i = 8'h00;
  logic [2:0] proximity_i = 3'd0;
  logic       motor_l_pwm_o, motor_r_pwm_o, motor_l_dir_o, motor_r_dir_o;
  logic [1:0] state_o;
  logic       new_cmd_o;

  int vectors = 0;
  int errors  = 0;
  int tb_cnt  = 0;
  int hl, hr;

  always #5 clk = ~clk;

  follow_ctrl #(
    .c_nb_centroid (8),
    .c_nb_prox     (3),
    .c_pwm_period  (P),
    .c_duty_max    (80),
    .c_search_duty (40),
    .c_slow_prox   (3),
    .c_stop_prox   (4),
    .c_lost_frames (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .new_centroid_i (new_centroid_i),
    .centroid_i     (centroid_i),
    .proximity_i    (proximity_i),
    .motor_l_pwm_o  (motor_l_pwm_o),
    .motor_r_pwm_o  (motor_r_pwm_o),
    .motor_l_dir_o  (motor_l_dir_o),
    .motor_r_dir_o  (motor_r_dir_o),
    .state_o        (state_o),
    .new_cmd_o      (new_cmd_o)
  );

  // Reference for the free-running PWM counter position.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == P - 1) ? 0 : tb_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
  endtask

  task automatic frame(input logic [7:0] c, input logic [2:0] p);
    new_centroid_i = 1'b1;
    centroid_i     = c;
    proximity_i    = p;
    tick();
    new_centroid_i = 1'b0;
    centroid_i     = 8'h00;
  endtask

  task automatic measure(input string tag, input int el, input int er);
    repeat (P + 5) tick();
    hl = 0;
    hr = 0;
    repeat (P) begin
      tick();
      hl += int'(motor_l_pwm_o);
      hr += int'(motor_r_pwm_o);
    end
    check({tag, "_duty_l"}, hl, el);
    check({tag, "_duty_r"}, hr, er);
  endtask

  task automatic goto_cnt30();
    for (int k = 0; k < 2 * P && tb_cnt != 30; k++) tick();
  endtask

  initial begin
    // 1: reset, then enable enters SEARCH and spins left
    repeat (2) tick();
    check("rst_state", state_o, 0);
    check("rst_pwm_l", motor_l_pwm_o, 0);
    check("rst_pwm_r", motor_r_pwm_o, 0);
    check("rst_dir_l", motor_l_dir_o, 0);
    check("rst_dir_r", motor_r_dir_o, 0);
    check("rst_new_cmd", new_cmd_o, 0);
    rst = 1'b0;
    enable_i = 1'b1;
    tick();
    check("search_state", state_o, 1);
    measure("search", 40, 40);
    check("search_dir_l", motor_l_dir_o, 0);
    check("search_dir_r", motor_r_dir_o, 1);

    // 2: centred far target starts tracking
    frame(8'h18, 3'd1);
    check("track_state", state_o, 2);
    check("track_new_cmd", new_cmd_o, 1);
    tick();
    check("track_new_cmd_end", new_cmd_o, 0);
    measure("centre", 80, 80);
    check("track_dir_l", motor_l_dir_o, 1);
    check("track_dir_r", motor_r_dir_o, 1);

    // 3: steering, slowed and full base
    frame(8'h02, 3'd3);
    measure("left3_slow", 10, 40);
    frame(8'h40, 3'd0);
    measure("right3", 80, 20);

    // 4: lost counter resets on a target, then expires
    repeat (3) begin
      frame(8'h00, 3'd0);
      check("lost_keep", state_o, 2);
    end
    frame(8'h18, 3'd1);
    check("lost_recover", state_o, 2);
    repeat (3) begin
      frame(8'h00, 3'd0);
      check("lost_count", state_o, 2);
    end
    frame(8'h05, 3'd0);
    check("lost_expire", state_o, 1);
    measure("lost_search", 40, 40);

    // 5: hold on close centred target, release and steer
    frame(8'h18, 3'd1);
    check("reacq_state", state_o, 2);
    frame(8'h18, 3'd5);
    check("hold_state", state_o, 3);
    measure("hold", 0, 0);
    frame(8'h18, 3'd2);
    check("unhold_state", state_o, 2);
    measure("unhold", 80, 80);
    frame(8'h01, 3'd6);
    check("left4_state", state_o, 2);
    measure("left4_slow", 0, 40);

    // 6a: enable drop mid-period
    frame(8'h18, 3'd1);
    repeat (2 * P) tick();
    goto_cnt30();
    check("mid_pre_pwm_l", motor_l_pwm_o, 1);
    enable_i = 1'b0;
    tick();
    check("dis_state", state_o, 0);
    check("dis_pwm_l", motor_l_pwm_o, 0);
    check("dis_pwm_r", motor_r_pwm_o, 0);
    measure("dis", 0, 0);

    // 6b: reset mid-period
    enable_i = 1'b1;
    tick();
    check("reen_state", state_o, 1);
    frame(8'h18, 3'd1);
    repeat (2 * P) tick();
    goto_cnt30();
    check("rst_pre_pwm_r", motor_r_pwm_o, 1);
    rst = 1'b1;
    tick();
    check("mrst_state", state_o, 0);
    check("mrst_pwm_l", motor_l_pwm_o, 0);
    check("mrst_pwm_r", motor_r_pwm_o, 0);
    check("mrst_dir_l", motor_l_dir_o, 0);
    check("mrst_dir_r", motor_r_dir_o, 0);
    check("mrst_new_cmd", new_cmd_o, 0);
    rst = 1'b0;

    // 6c: disable wins over a simultaneous frame
    tick();
    check("post_rst_state", state_o, 1);
    frame(8'h18, 3'd1);
    check("pre_dis_state", state_o, 2);
    tick();
    enable_i = 1'b0;
    frame(8'h08, 3'd1);
    check("dis_frame_state", state_o, 0);
    check("dis_frame_new_cmd", new_cmd_o, 0);
    tick();
    check("dis_frame_new_cmd2", new_cmd_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
